// File: rtl/imem_uart_loader.sv
// Streams a little-endian word count and instruction words from a UART byte stream into instruction RAM.
// Define LOADER_CHECKSUM_EN to append and verify a modulo-256 checksum byte after the data phase.
module imem_uart_loader #(
    parameter int IMEM_ADDR_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_imem,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       imem_wen,
    output logic [IMEM_ADDR_WIDTH-3:0] imem_waddr,
    output logic [31:0]                imem_wdata,
    output logic                       cpu_hold,
    output logic                       load_busy,
    output logic                       load_done,
    output logic                       load_error
);

    localparam int WORD_AW = IMEM_ADDR_WIDTH - 2;
    // One extra bit so the index can hold the full depth as a terminal count.
    localparam int IDX_W = WORD_AW + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << WORD_AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_POST = S_CHECK;
`else
    localparam state_t S_POST = S_DONE;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           byte_cnt_q;
    logic [23:0]          asm_q;
    logic [IDX_W-1:0]     len_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 err_q;
    logic                 wen_q;
    logic [WORD_AW-1:0]   waddr_q;
    logic [31:0]          wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           sum_q;
`endif

    logic [31:0]          word_full;
    logic [IDX_W-1:0]     idx_inc;
    logic                 lane3;
    logic                 last_word;
    logic                 len_zero;
    logic                 len_over;

    always_comb begin
        word_full = {rx_data, asm_q};
        idx_inc   = idx_q + IDX_W'(1);
        lane3     = (byte_cnt_q == 2'd3);
        last_word = (idx_inc == len_q);
        len_zero  = (word_full == 32'd0);
        len_over  = (word_full > MAX_WORDS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_imem) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid && lane3) begin
                    if (len_zero) begin
                        state_d = S_POST;
                    end else if (len_over) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid && lane3 && last_word) begin
                    state_d = S_POST;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (!load_imem) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: byte assembly, counters and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_imem) begin
                        byte_cnt_q <= 2'd0;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= 8'd0;
`endif
                    end
                end
                S_LEN, S_DATA: begin
                    if (rx_valid) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0:    asm_q[7:0]   <= rx_data;
                            2'd1:    asm_q[15:8]  <= rx_data;
                            2'd2:    asm_q[23:16] <= rx_data;
                            default: ;
                        endcase
                        if (state_q == S_LEN) begin
                            if (lane3) begin
                                len_q <= word_full[IDX_W-1:0];
                                err_q <= len_over;
                            end
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            sum_q <= sum_q + rx_data;
`endif
                            if (lane3) begin
                                wen_q   <= 1'b1;
                                waddr_q <= idx_q[WORD_AW-1:0];
                                wdata_q <= word_full;
                                idx_q   <= idx_inc;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_valid) begin
                        err_q <= (rx_data != sum_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_hold   = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state_q)
            S_LEN, S_DATA, S_CHECK: begin
                cpu_hold  = 1'b1;
                load_busy = 1'b1;
            end
            S_DONE: begin
                load_done  = !err_q;
                load_error = err_q;
            end
            default: ;
        endcase
    end

    assign imem_wen   = wen_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader; expected RAM writes are queued as bytes are sent and checked as they appear.
module tb_imem_uart_loader;

    localparam int AW = 16;

    logic          clk;
    logic          reset;
    logic          load_imem;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          imem_wen;
    logic [AW-3:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_busy;
    logic          load_done;
    logic          load_error;

    typedef struct {
        logic [AW-3:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  tests;
    int  fails;
    int  wen_count;

    imem_uart_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_imem  (load_imem),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_wen   (imem_wen),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; outputs are observed on the falling edge, where the write port is also scored.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        @(negedge clk);
        if (imem_wen === 1'b1) begin
            wen_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("waddr", 64'(imem_waddr), 64'(e.addr));
                check("wdata", 64'(imem_wdata), 64'(e.data));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic write_word(input logic [AW-3:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
        send_word(w);
        check("write_latency", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_status(input string tag, input logic hold, input logic busy,
                                input logic done, input logic err);
        check({tag, "_hold"}, 64'(cpu_hold), 64'(hold));
        check({tag, "_busy"}, 64'(load_busy), 64'(busy));
        check({tag, "_done"}, 64'(load_done), 64'(done));
        check({tag, "_err"},  64'(load_error), 64'(err));
    endtask

    task automatic finish_load();
        load_imem = 1'b0;
        tick();
        check_status("idle_after", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int wc;
        tests     = 0;
        fails     = 0;
        wen_count = 0;
        reset     = 1'b1;
        load_imem = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tick();
        tick();
        check("rst_wen", 64'(imem_wen), 64'd0);
        check("rst_waddr", 64'(imem_waddr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // rx traffic while idle must not start anything
        send_word(32'h0000_0002);
        tick();
        check_status("idle_rx", 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_rx_wen", 64'(wen_count), 64'd0);

        // normal two-word load, bytes back to back so word 1 lane 0 arrives during the first write
        load_imem = 1'b1;
        tick();
        check_status("len", 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'h0000_0002);
        check_status("data", 1'b1, 1'b1, 1'b0, 1'b0);
        write_word('0, 32'h0000_0013);
        write_word(14'd1, 32'h0000_006F);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h82);
`endif
        check_status("normal", 1'b0, 1'b0, 1'b1, 1'b0);
        check("normal_wen_count", 64'(wen_count), 64'd2);
        for (int i = 0; i < 4; i++) tick();
        check_status("done_hold", 1'b0, 1'b0, 1'b1, 1'b0);
        finish_load();
        tick();
        check_status("no_retrigger_low", 1'b0, 1'b0, 1'b0, 1'b0);

        // zero length
        wc = wen_count;
        load_imem = 1'b1;
        tick();
        send_word(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check_status("zero_len", 1'b0, 1'b0, 1'b1, 1'b0);
        check("zero_len_wen", 64'(wen_count), 64'(wc));
        finish_load();

        // oversize length 16385 words
        load_imem = 1'b1;
        tick();
        send_word(32'h0000_4001);
        check_status("oversize", 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'hDEAD_BEEF);
        check("oversize_wen", 64'(wen_count), 64'(wc));
        finish_load();

        // reset part way through the second word
        load_imem = 1'b1;
        tick();
        send_word(32'h0000_0002);
        write_word('0, 32'h4433_2211);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wc = wen_count;
        reset = 1'b1;
        tick();
        check("midrst_wen", 64'(imem_wen), 64'd0);
        check("midrst_waddr", 64'(imem_waddr), 64'd0);
        check("midrst_wdata", 64'(imem_wdata), 64'd0);
        check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        load_imem = 1'b0;
        tick();
        check("midrst_nowrite", 64'(wen_count), 64'(wc));

        // fresh load after reset starts at word 0; load_imem dropped mid-load is ignored
        load_imem = 1'b1;
        tick();
        send_word(32'h0000_0001);
        load_imem = 1'b0;
        write_word('0, 32'h0000_0013);
`ifdef LOADER_CHECKSUM_EN
        check_status("drop_check", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h13);
`endif
        check_status("drop_done", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_status("drop_idle", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // bad checksum: the word is still written, then an error is flagged
        load_imem = 1'b1;
        tick();
        send_word(32'h0000_0001);
        write_word('0, 32'h0000_0013);
        send_byte(8'h14);
        check_status("bad_sum", 1'b0, 1'b0, 1'b0, 1'b1);
        finish_load();
`endif

        tick();
        check("left_over_writes", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

Interface
REQ-001 The block SHALL have parameter IMEM_ADDR_WIDTH, default 16: instruction RAM byte-address width; word depth is 2^(IMEM_ADDR_WIDTH-2).
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_imem  input  1  level request to start a load.
REQ-005 rx_valid  input  1  one-cycle strobe for a received UART byte.
REQ-006 rx_data  input  8  received byte; valid only while rx_valid=1.
REQ-007 imem_wen  output  1  instruction RAM word write enable.
REQ-008 imem_waddr  output  IMEM_ADDR_WIDTH-2  instruction RAM word address.
REQ-009 imem_wdata  output  32  instruction RAM write word.
REQ-010 cpu_hold  output  1  holds the CPU in reset while a load is in progress.
REQ-011 load_busy  output  1  load in progress.
REQ-012 load_done  output  1  load finished; held until load_imem=0.
REQ-013 load_error  output  1  load failed; held until load_imem=0.

Function
REQ-014 The block SHALL implement states IDLE, LEN, DATA, CHECK and DONE; CHECK exists only under the configuration macro (REQ-029).
- IDLE → LEN: load_imem=1 sampled.
- Entering LEN SHALL clear the byte counter, word index and checksum, and set cpu_hold=1 and load_busy=1.
REQ-015 In LEN, the block SHALL assemble 4 rx bytes little-endian into a 32-bit word count N.
REQ-016 On the 4th LEN byte, the block SHALL transition as follows:
- N=0: go to CHECK if the macro is defined, otherwise to DONE.
- N > 2^(IMEM_ADDR_WIDTH-2): set load_error=1, go to DONE, perform no writes.
- Otherwise: go to DATA.
REQ-017 In DATA, each rx_valid byte SHALL fill byte lane byte_cnt (0 = bits 7:0) of the assembly register; byte_cnt wraps 3→0.
REQ-018 On the cycle after the rx_valid carrying lane 3, the block SHALL drive imem_wen=1 for exactly one cycle, with imem_waddr = word index and imem_wdata = the assembled word.
REQ-019 The word index SHALL increment after each write.
REQ-020 When the word index reaches N, the block SHALL go to CHECK (macro defined) or DONE.
REQ-021 imem_waddr and imem_wdata SHALL be don't-care when imem_wen=0; they SHALL be 0 after reset.
REQ-022 DONE SHALL set cpu_hold=0, load_busy=0, and load_done=1 (success) or load_error=1 (failure).
REQ-023 The block SHALL remain in DONE while load_imem=1 and SHALL return to IDLE the cycle after load_imem=0, clearing load_done and load_error; no re-trigger occurs without a deassertion.
REQ-024 rx_valid SHALL be ignored in IDLE and DONE.
REQ-025 Deassertion of load_imem during LEN, DATA or CHECK SHALL be ignored; the load runs to completion.
REQ-026 rx_valid on the same cycle as imem_wen SHALL be accepted as the next lane-0 byte without loss.

Reset
REQ-027 When reset=1, the block SHALL:
- enter IDLE;
- zero all counters, the assembly register and the checksum;
- drive every output to 0.
REQ-028 Reset mid-load SHALL abandon the load: no further imem_wen, already-written words are left untouched, and the next load starts at word 0.

Configuration
REQ-029 With macro LOADER_CHECKSUM_EN defined:
- the block SHALL accumulate the 8-bit modulo-256 sum of all DATA bytes (length bytes excluded);
- in CHECK, the next rx byte SHALL be compared with the sum: equal → DONE with load_done=1; unequal → DONE with load_error=1 (words already written remain).
REQ-030 Without LOADER_CHECKSUM_EN, the block SHALL omit the CHECK state and the checksum logic, and a completed DATA phase SHALL go directly to DONE with load_done=1.

Verification
REQ-031 Normal load: load_imem=1, bytes 02 00 00 00 13 00 00 00 6F 00 00 00 (plus checksum 0x82 if macro defined) → two writes, addr0=0x00000013 then addr1=0x0000006F, each one cycle after its 4th byte; then load_done=1, cpu_hold=0.
REQ-032 Zero length: bytes 00 00 00 00 (plus 00 if macro defined) → no imem_wen, load_done=1.
REQ-033 Oversize: IMEM_ADDR_WIDTH=16, length bytes 01 40 00 00 (N=16385) → load_error=1, no imem_wen, cpu_hold=0.
REQ-034 Reset mid-load: reset=1 after 2 DATA bytes → all outputs 0 the next cycle, no write; a new load writes from addr 0.
REQ-035 Checksum (macro defined): N=1, data 13 00 00 00, checksum 13 → load_done=1; checksum 14 → load_error=1, with addr0 still written.
REQ-036 Idle/handshake: rx_valid pulses in IDLE → no state change; load_imem held high in DONE → no restart until it is dropped and re-raised.
